// File: rtl/mask_rand_src.sv
// Seedable Galois LFSR issuing one fresh RAND_W-bit mask word per valid/ready handshake.
// First word follows a seed accept by WARMUP+1 cycles; a stalled word holds rand_o and the LFSR.
module mask_rand_src #(
  parameter int          RAND_W = 8,
  parameter int          WARMUP = 16,
  parameter logic [31:0] TAPS   = 32'h80200003
) (
  input  logic              C,
  input  logic              R,
  input  logic [31:0]       seed_i,
  input  logic              seed_valid_i,
  output logic              seed_ready_o,
  output logic [RAND_W-1:0] rand_o,
  output logic              rand_valid_o,
  input  logic              rand_ready_i,
  output logic [15:0]       word_cnt_o
);

  typedef enum logic [1:0] {
    ST_UNSEEDED = 2'd0,
    ST_WARMUP   = 2'd1,
    ST_RUN      = 2'd2
  } state_t;

  localparam logic [15:0] WARM_INIT = 16'(WARMUP);

  state_t            state_q, state_d;
  logic [31:0]       lfsr_q, lfsr_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [RAND_W-1:0] rand_q, rand_d;
  logic              rand_vld_q, rand_vld_d;
  logic [15:0]       word_cnt_q, word_cnt_d;
  logic              seed_acc;
  logic              consume;
  logic [31:0]       lfsr_f;

  // RAND_W unrolled single steps, so each issued word is fully fresh state.
  function automatic logic [31:0] step_f(input logic [31:0] s);
    logic [31:0] v;
    v = s;
    for (int i = 0; i < RAND_W; i++) begin
      v = v[0] ? ((v >> 1) ^ TAPS) : (v >> 1);
    end
    return v;
  endfunction

  assign lfsr_f       = step_f(lfsr_q);
  assign seed_ready_o = (state_q != ST_WARMUP);
  assign seed_acc     = seed_valid_i & seed_ready_o;
  assign consume      = rand_vld_q & rand_ready_i;

  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    cnt_d      = cnt_q;
    rand_d     = rand_q;
    rand_vld_d = rand_vld_q;
    word_cnt_d = word_cnt_q;

    if (consume && (word_cnt_q != 16'hFFFF)) begin
      word_cnt_d = word_cnt_q + 16'd1;
    end

    case (state_q)
      ST_WARMUP: begin
        lfsr_d = lfsr_f;
        cnt_d  = cnt_q - 16'd1;
        if (cnt_q == 16'd1) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!rand_vld_q || rand_ready_i) begin
          rand_d     = lfsr_q[RAND_W-1:0];
          lfsr_d     = lfsr_f;
          rand_vld_d = 1'b1;
        end
      end
      default: ;
    endcase

    // A new seed overrides everything, including a same-cycle consume's count.
    if (seed_acc) begin
      lfsr_d     = (seed_i == 32'h0) ? 32'h1 : seed_i;
      rand_d     = rand_q;
      rand_vld_d = 1'b0;
      word_cnt_d = 16'h0;
      if (WARMUP > 0) begin
        cnt_d   = WARM_INIT;
        state_d = ST_WARMUP;
      end else begin
        cnt_d   = 16'h0;
        state_d = ST_RUN;
      end
    end
  end

  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      state_q    <= ST_UNSEEDED;
      lfsr_q     <= 32'h1;
      cnt_q      <= 16'h0;
      rand_q     <= '0;
      rand_vld_q <= 1'b0;
      word_cnt_q <= 16'h0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      cnt_q      <= cnt_d;
      rand_q     <= rand_d;
      rand_vld_q <= rand_vld_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign rand_o       = rand_q;
  assign rand_valid_o = rand_vld_q;
  assign word_cnt_o   = word_cnt_q;

endmodule

// File: tb/tb_mask_rand_src.sv
// Directed bench: dut0 runs with WARMUP=0, dut16 with WARMUP=16; both share clock, reset and seed bus.
module tb_mask_rand_src;

  logic        C = 1'b0;
  logic        R = 1'b0;
  logic [31:0] seed_i = 32'h0;

  logic        sv0 = 1'b0, rr0 = 1'b0, sr0, vld0;
  logic [7:0]  rand0;
  logic [15:0] cnt0;

  logic        sv16 = 1'b0, rr16 = 1'b0, sr16, vld16;
  logic [7:0]  rand16;
  logic [15:0] cnt16;

  int nvec = 0;
  int nerr = 0;

  logic [31:0] m;
  logic [7:0]  exp_w;

  always #5 C = ~C;

  mask_rand_src #(.RAND_W(8), .WARMUP(0), .TAPS(32'h80200003)) dut0 (
    .C(C), .R(R), .seed_i(seed_i), .seed_valid_i(sv0), .seed_ready_o(sr0),
    .rand_o(rand0), .rand_valid_o(vld0), .rand_ready_i(rr0), .word_cnt_o(cnt0)
  );

  mask_rand_src #(.RAND_W(8), .WARMUP(16), .TAPS(32'h80200003)) dut16 (
    .C(C), .R(R), .seed_i(seed_i), .seed_valid_i(sv16), .seed_ready_o(sr16),
    .rand_o(rand16), .rand_valid_o(vld16), .rand_ready_i(rr16), .word_cnt_o(cnt16)
  );

  // Reference: eight Galois steps of x^32+x^22+x^2+x+1.
  function automatic logic [31:0] f8(input logic [31:0] s);
    logic [31:0] v;
    v = s;
    for (int i = 0; i < 8; i++) begin
      if (v[0]) v = (v >> 1) ^ 32'h80200003;
      else      v = v >> 1;
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge C);
    @(negedge C);
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_vld0", {31'b0, vld0}, 32'd0);
    chk("rst_rand0", {24'b0, rand0}, 32'd0);
    chk("rst_cnt0", {16'b0, cnt0}, 32'd0);
    chk("rst_sr0", {31'b0, sr0}, 32'd1);
    chk("rst_sr16", {31'b0, sr16}, 32'd1);
    @(negedge C);
    R = 1'b1; rr0 = 1'b1; rr16 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("unseeded_vld0", {31'b0, vld0}, 32'd0);
      chk("unseeded_vld16", {31'b0, vld16}, 32'd0);
    end
    chk("unseeded_sr0", {31'b0, sr0}, 32'd1);
    chk("unseeded_cnt0", {16'b0, cnt0}, 32'd0);

    // WARMUP=0, seed 1
    seed_i = 32'h1; sv0 = 1'b1;
    tick();
    sv0 = 1'b0;
    chk("s1_vld_after_accept", {31'b0, vld0}, 32'd0);
    tick();
    chk("s1_w0_vld", {31'b0, vld0}, 32'd1);
    chk("s1_w0", {24'b0, rand0}, 32'h01);
    chk("s1_w0_cnt", {16'b0, cnt0}, 32'd0);
    tick();
    chk("s1_w1", {24'b0, rand0}, 32'h02);
    chk("s1_w1_cnt", {16'b0, cnt0}, 32'd1);

    // Stall: word and count frozen, no skipped word after release
    m = f8(32'hDB36C002);
    rr0 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_w", {24'b0, rand0}, 32'h02);
      chk("stall_cnt", {16'b0, cnt0}, 32'd1);
      chk("stall_vld", {31'b0, vld0}, 32'd1);
    end
    rr0 = 1'b1;
    tick();
    exp_w = m[7:0];
    chk("after_stall_w", {24'b0, rand0}, {24'b0, exp_w});
    chk("after_stall_cnt", {16'b0, cnt0}, 32'd2);

    // Seed collides with a consume: seed wins
    seed_i = 32'h1; sv0 = 1'b1;
    tick();
    sv0 = 1'b0;
    chk("coll_vld", {31'b0, vld0}, 32'd0);
    chk("coll_cnt", {16'b0, cnt0}, 32'd0);
    tick();
    chk("coll_w0", {24'b0, rand0}, 32'h01);
    chk("coll_w0_vld", {31'b0, vld0}, 32'd1);

    // Seed 0 maps to seed 1
    seed_i = 32'h0; sv0 = 1'b1;
    tick();
    sv0 = 1'b0;
    chk("s0_vld_after_accept", {31'b0, vld0}, 32'd0);
    tick();
    chk("s0_w0", {24'b0, rand0}, 32'h01);
    tick();
    chk("s0_w1", {24'b0, rand0}, 32'h02);
    chk("s0_cnt", {16'b0, cnt0}, 32'd1);

    // WARMUP=16: seed_ready low for 16 edges, stray seed ignored
    m = 32'h12345678;
    for (int i = 0; i < 16; i++) m = f8(m);
    exp_w = m[7:0];
    seed_i = 32'h12345678; sv16 = 1'b1;
    tick();
    seed_i = 32'h1;
    for (int i = 0; i < 16; i++) begin
      chk("warm_sr", {31'b0, sr16}, 32'd0);
      chk("warm_vld", {31'b0, vld16}, 32'd0);
      sv16 = (i == 5);
      tick();
    end
    sv16 = 1'b0;
    chk("warm_end_sr", {31'b0, sr16}, 32'd1);
    chk("warm_end_vld", {31'b0, vld16}, 32'd0);
    tick();
    chk("warm_first_vld", {31'b0, vld16}, 32'd1);
    chk("warm_first_w", {24'b0, rand16}, {24'b0, exp_w});

    // Mid-stream asynchronous reset: dut0 pending word, dut16 in warm-up
    rr0 = 1'b0;
    seed_i = 32'h1; sv0 = 1'b1; sv16 = 1'b1;
    tick();
    sv0 = 1'b0; sv16 = 1'b0;
    tick();
    chk("pre_rst_vld0", {31'b0, vld0}, 32'd1);
    chk("pre_rst_w0", {24'b0, rand0}, 32'h01);
    chk("pre_rst_sr16", {31'b0, sr16}, 32'd0);
    #2;
    R = 1'b0;
    #1;
    chk("arst_vld0", {31'b0, vld0}, 32'd0);
    chk("arst_rand0", {24'b0, rand0}, 32'd0);
    chk("arst_cnt0", {16'b0, cnt0}, 32'd0);
    chk("arst_sr16", {31'b0, sr16}, 32'd1);
    chk("arst_vld16", {31'b0, vld16}, 32'd0);
    chk("arst_rand16", {24'b0, rand16}, 32'd0);
    chk("arst_cnt16", {16'b0, cnt16}, 32'd0);
    @(negedge C);
    R = 1'b1;
    tick();
    chk("post_rst_vld0", {31'b0, vld0}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
